// File: rtl/mem_stage_if.sv
// Data-bus interface between the MEM stage and the data memory.
// One access is outstanding at a time; ack may arrive in the request cycle.
//   req   : access request, held stable until ack
//   we    : 1 = store, 0 = load
//   addr  : word-aligned byte address
//   sel   : byte lanes, bit 3 = lane [31:24] (big-endian offset 0)
//   wdata : store data, replicated across lanes
//   rdata : load data, only meaningful while ack=1
//   ack   : completion strobe
interface mem_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, we, addr, sel, wdata, input rdata, ack);
   modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage MIPS pipeline. Performs big-endian
// byte/halfword/word loads and stores over a single-outstanding data bus and
// requests a pipeline stall while an access is pending. Non-memory ops pass
// straight through to write-back.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall[5:0]          : ctrl stall vector, only stall[4] (MEM/WB hold) used
//   mem_*               : EX/MEM register fields (result, hi/lo, CP0, address,
//                         op code, store source)
//   wb_*                : fields forwarded to MEM/WB
//   stallreq_mem        : stall request while an access waits for ack
//   addr_misaligned     : current memory op violates natural alignment
//   dbus                : data bus (master side)
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic [31:0] mem_wdata,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic        mem_whilo,
   input  logic [31:0] mem_hi,
   input  logic [31:0] mem_lo,
   input  logic        mem_cp0_we,
   input  logic [4:0]  mem_cp0_waddr,
   input  logic [31:0] mem_cp0_wdata,
   input  logic [31:0] mem_mem_addr,
   input  logic [7:0]  mem_aluop,
   input  logic [31:0] mem_reg2,
   output logic [31:0] wb_wdata,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic        wb_whilo,
   output logic [31:0] wb_hi,
   output logic [31:0] wb_lo,
   output logic        wb_cp0_we,
   output logic [4:0]  wb_cp0_waddr,
   output logic [31:0] wb_cp0_wdata,
   output logic        stallreq_mem,
   output logic        addr_misaligned,
   mem_stage_if.master dbus
);

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

   state_t      state, state_nx;
   logic [31:0] rdata_q;
   logic        is_load, is_store, sext, memop, aligned, access, req_raw;
   logic [1:0]  size;
   logic [1:0]  off;
   logic        unused_stall;

   assign unused_stall = ^{stall[5], stall[3:0]};
   assign off          = mem_mem_addr[1:0];

   // Pick the addressed lane out of a big-endian word and extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] w,
                                               input logic [1:0]  o,
                                               input logic [1:0]  sz,
                                               input logic        sx);
      logic [7:0]  b;
      logic [15:0] h;
      case (o)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = o[1] ? w[15:0] : w[31:16];
      case (sz)
         SZ_BYTE: load_extend = sx ? {{24{b[7]}}, b}  : {24'b0, b};
         SZ_HALF: load_extend = sx ? {{16{h[15]}}, h} : {16'b0, h};
         default: load_extend = w;
      endcase
   endfunction

   // Op decode
   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      sext     = 1'b0;
      size     = SZ_WORD;
      case (mem_aluop)
         EXE_LB_OP:  begin is_load  = 1'b1; sext = 1'b1; size = SZ_BYTE; end
         EXE_LBU_OP: begin is_load  = 1'b1;              size = SZ_BYTE; end
         EXE_LH_OP:  begin is_load  = 1'b1; sext = 1'b1; size = SZ_HALF; end
         EXE_LHU_OP: begin is_load  = 1'b1;              size = SZ_HALF; end
         EXE_LW_OP:  begin is_load  = 1'b1;              size = SZ_WORD; end
         EXE_SB_OP:  begin is_store = 1'b1;              size = SZ_BYTE; end
         EXE_SH_OP:  begin is_store = 1'b1;              size = SZ_HALF; end
         EXE_SW_OP:  begin is_store = 1'b1;              size = SZ_WORD; end
         default:    ;
      endcase
   end

   assign memop   = is_load | is_store;
   assign aligned = (size == SZ_HALF) ? ~off[0] :
                    (size == SZ_WORD) ? (off == 2'b00) : 1'b1;
   assign access  = memop & aligned;
   // HOLD means the access already completed; never re-issue it.
   assign req_raw = access & (state != HOLD);

   // State register and load-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rdata_q <= 32'b0;
      end else begin
         state <= state_nx;
         if (req_raw && dbus.ack && is_load)
            rdata_q <= dbus.rdata;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (access) state_nx = dbus.ack ? (stall[4] ? HOLD : IDLE) : BUSY;
         // If the op vanishes under us the request drops; don't wait on an
         // ack that will never come.
         BUSY: if (!access)     state_nx = IDLE;
               else if (dbus.ack) state_nx = stall[4] ? HOLD : IDLE;
         HOLD: if (!stall[4])   state_nx = IDLE;
         default:               state_nx = IDLE;
      endcase
   end

   // Outputs, all forced to zero while reset is asserted
   always_comb begin
      wb_wdata        = 32'b0;
      wb_wd           = 5'b0;
      wb_wreg         = 1'b0;
      wb_whilo        = 1'b0;
      wb_hi           = 32'b0;
      wb_lo           = 32'b0;
      wb_cp0_we       = 1'b0;
      wb_cp0_waddr    = 5'b0;
      wb_cp0_wdata    = 32'b0;
      stallreq_mem    = 1'b0;
      addr_misaligned = 1'b0;
      dbus.req        = 1'b0;
      dbus.we         = 1'b0;
      dbus.addr       = 32'b0;
      dbus.sel        = 4'b0;
      dbus.wdata      = 32'b0;
      if (!rst) begin
         wb_wdata        = mem_wdata;
         wb_wd           = mem_wd;
         wb_wreg         = mem_wreg;
         wb_whilo        = mem_whilo;
         wb_hi           = mem_hi;
         wb_lo           = mem_lo;
         wb_cp0_we       = mem_cp0_we;
         wb_cp0_waddr    = mem_cp0_waddr;
         wb_cp0_wdata    = mem_cp0_wdata;
         addr_misaligned = memop & ~aligned;
         dbus.req        = req_raw;
         stallreq_mem    = req_raw & ~dbus.ack;
         dbus.we         = is_store;
         dbus.addr       = {mem_mem_addr[31:2], 2'b00};
         case (size)
            SZ_BYTE: begin
               dbus.sel   = 4'b1000 >> off;
               dbus.wdata = {4{mem_reg2[7:0]}};
            end
            SZ_HALF: begin
               dbus.sel   = off[1] ? 4'b0011 : 4'b1100;
               dbus.wdata = {2{mem_reg2[15:0]}};
            end
            default: begin
               dbus.sel   = 4'b1111;
               dbus.wdata = mem_reg2;
            end
         endcase
         if (memop && !aligned) begin
            wb_wreg  = 1'b0;
            wb_wdata = 32'b0;
         end else if (is_load) begin
            if (state == HOLD)
               wb_wdata = load_extend(rdata_q, off, size, sext);
            else if (dbus.ack)
               wb_wdata = load_extend(dbus.rdata, off, size, sext);
            else
               wb_wdata = 32'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: stimulus pushes expected write-back/bus behaviour into
// a queue, a monitor checks the bus every cycle and pops at retirement.
module tb_mem_stage;

   localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4,
                          LHU = 8'hE5, SB = 8'hE8, SH = 8'hE9, SW = 8'hEB,
                          OR_OP = 8'h25;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [31:0] mem_wdata, mem_hi, mem_lo, mem_cp0_wdata, mem_mem_addr, mem_reg2;
   logic [4:0]  mem_wd, mem_cp0_waddr;
   logic        mem_wreg, mem_whilo, mem_cp0_we;
   logic [7:0]  mem_aluop;
   logic [31:0] wb_wdata, wb_hi, wb_lo, wb_cp0_wdata;
   logic [4:0]  wb_wd, wb_cp0_waddr;
   logic        wb_wreg, wb_whilo, wb_cp0_we, stallreq_mem, addr_misaligned;

   mem_stage_if bus_if();

   mem_stage dut (
      .clk(clk), .rst(rst), .stall(stall),
      .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_cp0_we(mem_cp0_we), .mem_cp0_waddr(mem_cp0_waddr),
      .mem_cp0_wdata(mem_cp0_wdata), .mem_mem_addr(mem_mem_addr),
      .mem_aluop(mem_aluop), .mem_reg2(mem_reg2),
      .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
      .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
      .wb_cp0_we(wb_cp0_we), .wb_cp0_waddr(wb_cp0_waddr),
      .wb_cp0_wdata(wb_cp0_wdata), .stallreq_mem(stallreq_mem),
      .addr_misaligned(addr_misaligned), .dbus(bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] addr, reg2, rdata, wdata, hi, lo, cp0_wdata;
      logic [4:0]  wd, cp0_waddr;
      logic        wreg, whilo, cp0_we;
      int          waits, hold;
   } stim_t;

   typedef struct {
      logic [31:0] wdata, hi, lo, cp0_wdata, baddr, bwdata;
      logic [4:0]  wd, cp0_waddr;
      logic        wreg, whilo, cp0_we, mis, access, we;
      logic [3:0]  sel;
      int          stalls, acks;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   int          n_cmp = 0, n_bad = 0, retired = 0;
   int          cur_wait = 0, wcnt = 0, st_cnt = 0, ack_cnt = 0;
   logic [31:0] cur_rdata = 32'b0;
   logic [31:0] rst_or;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: treat an access as n consecutive big-endian bytes starting
   // at byte offset addr%4 of the word.
   function automatic exp_t model(input stim_t s);
      exp_t        e;
      int          n, off;
      logic        sx, ld;
      logic [31:0] v;
      n = 0; sx = 1'b0;
      case (s.op)
         LB:  begin n = 1; sx = 1'b1; end
         LBU: n = 1;
         LH:  begin n = 2; sx = 1'b1; end
         LHU: n = 2;
         LW:  n = 4;
         SB:  n = 1;
         SH:  n = 2;
         SW:  n = 4;
         default: n = 0;
      endcase
      ld       = (s.op == LB || s.op == LBU || s.op == LH || s.op == LHU || s.op == LW);
      off      = int'(s.addr % 4);
      e.mis    = (n != 0) && (s.addr % n != 0);
      e.access = (n != 0) && !e.mis;
      e.we     = (n != 0) && !ld;
      e.baddr  = s.addr - off;
      e.sel    = 4'b0;
      v        = 32'b0;
      for (int k = off; k < off + n && k < 4; k++) begin
         e.sel[3-k] = 1'b1;
         v = (v << 8) | ((s.rdata >> (8 * (3 - k))) & 32'hFF);
      end
      if (sx && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      e.bwdata    = (n == 1) ? (s.reg2 & 32'hFF) * 32'h0101_0101 :
                    (n == 2) ? (s.reg2 & 32'hFFFF) * 32'h0001_0001 : s.reg2;
      e.wreg      = e.mis ? 1'b0 : s.wreg;
      e.wdata     = e.mis ? 32'b0 : (ld ? v : s.wdata);
      e.wd        = s.wd;
      e.whilo     = s.whilo;
      e.hi        = s.hi;
      e.lo        = s.lo;
      e.cp0_we    = s.cp0_we;
      e.cp0_waddr = s.cp0_waddr;
      e.cp0_wdata = s.cp0_wdata;
      e.stalls    = e.access ? s.waits : 0;
      e.acks      = e.access ? 1 : 0;
      return e;
   endfunction

   function automatic stim_t mk(input logic [7:0] op, input logic [31:0] addr,
                                input logic [31:0] reg2, input logic [31:0] rdata,
                                input int waits, input int hold);
      stim_t s;
      s.op = op; s.addr = addr; s.reg2 = reg2; s.rdata = rdata;
      s.waits = waits; s.hold = hold;
      s.wdata = $urandom; s.hi = $urandom; s.lo = $urandom; s.cp0_wdata = $urandom;
      s.wd = 5'($urandom); s.cp0_waddr = 5'($urandom);
      s.whilo = 1'($urandom); s.cp0_we = 1'($urandom);
      if (op inside {LB, LBU, LH, LHU, LW}) s.wreg = 1'b1;
      else if (op inside {SB, SH, SW})      s.wreg = 1'b0;
      else                                  s.wreg = 1'($urandom);
      return s;
   endfunction

   task automatic drive(input stim_t s);
      mem_aluop = s.op; mem_mem_addr = s.addr; mem_reg2 = s.reg2;
      mem_wdata = s.wdata; mem_wd = s.wd; mem_wreg = s.wreg;
      mem_whilo = s.whilo; mem_hi = s.hi; mem_lo = s.lo;
      mem_cp0_we = s.cp0_we; mem_cp0_waddr = s.cp0_waddr; mem_cp0_wdata = s.cp0_wdata;
   endtask

   // Present one instruction and hold it until the monitor retires it.
   task automatic issue(input stim_t s);
      int start;
      q.push_back(model(s));
      drive(s);
      cur_wait  = s.waits;
      cur_rdata = s.rdata;
      start     = retired;
      for (int k = 0; k < 60; k++) begin
         stall = {1'b0, (s.hold > 0) && (k <= s.waits + s.hold), 4'b0};
         @(posedge clk); #1;
         if (retired != start) begin
            stall = 6'b0;
            return;
         end
      end
      n_cmp++; n_bad++;
      $display("FAIL retire_timeout: op %0h addr %0h not retired in 60 cycles", s.op, s.addr);
      q.delete();
      stall = 6'b0;
   endtask

   // Bus slave: ack after cur_wait request cycles, garbage rdata otherwise.
   always @(negedge clk) begin
      if (rst || bus_if.ack) wcnt = 0;
      else if (bus_if.req)   wcnt++;
   end

   always @(posedge clk) begin
      #2;
      bus_if.ack   = !rst && bus_if.req && (wcnt == cur_wait);
      bus_if.rdata = bus_if.ack ? cur_rdata : $urandom;
   end

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         rst_or = wb_wdata | wb_hi | wb_lo | wb_cp0_wdata | bus_if.addr | bus_if.wdata |
                  {11'b0, wb_wd, wb_wreg, wb_whilo, wb_cp0_we, wb_cp0_waddr,
                   stallreq_mem, addr_misaligned, bus_if.req, bus_if.we, bus_if.sel};
         chk("reset_outputs_zero", rst_or, 32'b0);
         st_cnt = 0; ack_cnt = 0;
      end else if (q.size() > 0) begin
         me = q[0];
         chk("addr_misaligned", {31'b0, addr_misaligned}, {31'b0, me.mis});
         if (bus_if.req) begin
            chk("req_allowed", 32'd1, {31'b0, me.access});
            chk("dbus_we",    {31'b0, bus_if.we}, {31'b0, me.we});
            chk("dbus_addr",  bus_if.addr, me.baddr);
            chk("dbus_sel",   {28'b0, bus_if.sel}, {28'b0, me.sel});
            if (me.we) chk("dbus_wdata", bus_if.wdata, me.bwdata);
         end
         if (stallreq_mem) st_cnt++;
         if (bus_if.req && bus_if.ack) ack_cnt++;
         if (!stallreq_mem && !stall[4]) begin
            chk("wb_wdata",     wb_wdata, me.wdata);
            chk("wb_wreg",      {31'b0, wb_wreg}, {31'b0, me.wreg});
            chk("wb_wd",        {27'b0, wb_wd}, {27'b0, me.wd});
            chk("wb_hilo",      wb_hi ^ wb_lo ^ {31'b0, wb_whilo}, me.hi ^ me.lo ^ {31'b0, me.whilo});
            chk("wb_cp0",       wb_cp0_wdata ^ {26'b0, wb_cp0_we, wb_cp0_waddr},
                                me.cp0_wdata ^ {26'b0, me.cp0_we, me.cp0_waddr});
            chk("stall_cycles", st_cnt, me.stalls);
            chk("bus_accesses", ack_cnt, me.acks);
            void'(q.pop_front());
            retired++;
            st_cnt = 0; ack_cnt = 0;
         end
      end
   end

   initial begin
      stim_t s;
      logic [7:0] ops [9];
      ops[0] = LB; ops[1] = LBU; ops[2] = LH; ops[3] = LHU; ops[4] = LW;
      ops[5] = SB; ops[6] = SH;  ops[7] = SW; ops[8] = OR_OP;

      bus_if.ack = 1'b0; bus_if.rdata = 32'b0;
      stall = 6'b0;
      rst = 1'b1;
      drive(mk(LW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0));  // busy inputs under reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      issue(mk(LW,  32'h100, 32'h0,        32'h8899AABB, 0, 0));
      issue(mk(LB,  32'h103, 32'h0,        32'h000000F0, 2, 0));
      issue(mk(LBU, 32'h103, 32'h0,        32'h000000F0, 2, 0));
      issue(mk(SH,  32'h202, 32'h1234ABCD, 32'h0,        1, 0));
      issue(mk(LW,  32'h101, 32'h0,        32'h12345678, 0, 0));
      issue(mk(LHU, 32'h000, 32'h0,        32'hBEEF0000, 0, 3));
      issue(mk(LH,  32'h006, 32'h0,        32'h00008001, 2, 2));

      // Reset in the middle of a waiting LW, then flush to a non-memory op.
      s = mk(LW, 32'h40, 32'h0, 32'hCAFEF00D, 5, 0);
      q.push_back(model(s));
      drive(s);
      cur_wait = 5; cur_rdata = s.rdata;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      q.delete();
      drive(mk(OR_OP, 32'h0, 32'h0, 32'h0, 0, 0));
      @(posedge clk); #1;
      rst = 1'b0;
      issue(mk(OR_OP, 32'h44, 32'h0, 32'h0, 0, 0));
      issue(mk(LW,    32'h48, 32'h0, 32'h01020304, 0, 0));

      for (int i = 0; i < 40; i++) begin
         s = mk(ops[$urandom_range(8)], $urandom, $urandom, $urandom,
                $urandom_range(3), $urandom_range(2));
         issue(s);
      end

      repeat (2) @(posedge clk);
      #1 chk("queue_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the OPEN_MIPS five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It performs big-endian loads and stores (LB, LBU, LH, LHU, LW, SB, SH, SW) over a single-outstanding req/ack data bus. While an access is in flight it requests a pipeline stall; all other operations pass straight through to write-back.

## Interface
- No parameters; widths come from the project defines: `RegBus` is 32b, `RegAddrBus` is 5b, `AluOpBus` is 8b.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  6  ctrl stall vector; only stall[4] (MEM/WB hold) is used.
- mem_wdata, mem_wd, mem_wreg, mem_whilo, mem_hi, mem_lo  in  32/5/1/1/32/32  EX/MEM result fields.
- mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata  in  1/5/32  EX/MEM CP0 write fields.
- mem_mem_addr  in  32  effective byte address.
- mem_aluop  in  8  op code (EXE_LB_OP … EXE_SW_OP).
- mem_reg2  in  32  store data source.
- wb_wdata, wb_wd, wb_wreg, wb_whilo, wb_hi, wb_lo  out  32/5/1/1/32/32  to MEM/WB.
- wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata  out  1/5/32  to MEM/WB.
- stallreq_mem  out  1  stall request to ctrl.
- addr_misaligned  out  1  current memory op is misaligned.
- dbus_req, dbus_we  out  1/1  bus request; write enable.
- dbus_addr  out  32  bus address: {mem_mem_addr[31:2], 2'b00}.
- dbus_sel  out  4  byte lanes; bit 3 = byte lane rdata/wdata[31:24].
- dbus_wdata  out  32  store data.
- dbus_rdata  in  32  load data; valid only with dbus_ack.
- dbus_ack  in  1  completion strobe; may arrive in the same cycle as the request.

## Operation
- memop = aluop is one of the 8 load/store codes. aligned = halfword ops need addr[0]=0; word ops need addr[1:0]=0; byte ops are always aligned. addr_misaligned = memop & ~aligned.
- Byte lanes are big-endian. The byte at offset 0 is bits [31:24], sel 4'b1000.
  - Byte sel = 4'b1000 >> addr[1:0].
  - Halfword sel = addr[1] ? 4'b0011 : 4'b1100.
  - Word sel = 4'b1111.
- Stores replicate data across lanes: SB uses {4{reg2[7:0]}}, SH uses {2{reg2[15:0]}}, SW uses reg2 unchanged.
- Loads extract the selected lane, then sign-extend (LB, LH) or zero-extend (LBU, LHU). LW returns the full word.
- State machine, 2-bit register, states IDLE, BUSY and HOLD:
  - IDLE: if memop & aligned, drive the request. On dbus_ack: go to HOLD if stall[4]=Stop, else stay in IDLE. With no ack: go to BUSY.
  - BUSY: hold the request stable. On dbus_ack: go to HOLD if stall[4]=Stop, else IDLE.
  - HOLD: the access is complete and the instruction is still held in EX/MEM. No new request is issued. Go to IDLE when stall[4]=NoStop.
- dbus_req = memop & aligned & (state≠HOLD). dbus_we = op is a store. dbus_addr, sel and wdata are valid whenever dbus_req=1, and stay constant through BUSY.
- On dbus_ack for a load, dbus_rdata is captured into rdata_q, which is used in HOLD.
- stallreq_mem = memop & aligned & (state≠HOLD) & ~dbus_ack.
- Write-back outputs:
  - Non-memop: all wb_* fields equal the corresponding mem_* inputs.
  - Store: wb_* fields pass through unchanged; EX already drives wreg=0 for stores.
  - Load:
    - Ack cycle: wb_wdata = extended dbus_rdata.
    - HOLD: wb_wdata = extended rdata_q.
    - Otherwise: wb_wdata = 0.
    - wb_wreg = mem_wreg in all load cases.
  - Misaligned op: no bus access, wb_wreg=0, wb_wdata=0, stallreq_mem=0.
- Reset (rst=1 at an edge): state goes to IDLE and rdata_q to 0.
  - While rst=1, all outputs are forced to 0 combinationally, including wb_wd = NOPRegAddr and dbus_req=0.
  - Reset during BUSY abandons the access. The bus must tolerate the request being dropped.

## Timing
- Zero-wait access (ack in the same cycle as the request): stallreq_mem=0, and the instruction moves to MEM/WB at the next edge. Latency is 1 cycle.
- With N wait cycles, stallreq_mem is high for N cycles. The ack cycle drops the stall, so total latency is N+1 cycles.
- All outputs are combinational from the inputs, the state and rdata_q. No output is registered except through the state register.
- A HOLD stay never re-issues the bus transaction, whatever its length.

## Test plan
- **LW, zero-wait:** addr=0x100, ack in the same cycle, rdata=0x8899AABB -> wb_wdata=0x8899AABB, wb_wreg=1, stallreq_mem=0, dbus_sel=4'b1111.
- **LB and LBU with wait states:** addr=0x103, rdata=0x000000F0, ack after 2 wait cycles.
  - stallreq_mem is high exactly 2 cycles and dbus_sel=4'b0001 throughout.
  - wb_wdata=0xFFFFFFF0 for LB and 0x000000F0 for LBU.
- **SH:** addr=0x202, reg2=0x1234ABCD -> dbus_we=1, dbus_sel=4'b0011, dbus_wdata=0xABCDABCD, dbus_addr=0x200.
- **Misaligned:** LW at 0x101 -> addr_misaligned=1, dbus_req=0, wb_wreg=0, stallreq_mem=0.
- **HOLD path:** external stall[4]=Stop at the ack cycle of LHU, addr 0x0, rdata=0xBEEF0000.
  - FSM enters HOLD, no second request is issued, and wb_wdata=0x0000BEEF until stall[4] drops.
  - FSM then returns to IDLE.
- **Reset mid-BUSY:** rst=1 for one edge during a pending LW -> next cycle state=IDLE, dbus_req=0, and all wb_* outputs are 0 while rst=1.
